// File: rtl/uart_cmd_controller.sv
// Byte-oriented command decoder: AA <addr> <data> writes a register, BB <addr> reads one
// and returns the value as a single response byte toward the TX FIFO.
module uart_cmd_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  cmd_error
);

  localparam logic [DATA_WIDTH-1:0] OP_WRITE = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_READ  = DATA_WIDTH'(8'hBB);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_PUSH = 3'd5
  } state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   rf_addr_r, rf_addr_s;
  logic [DATA_WIDTH-1:0]   rf_wr_data_r, rf_wr_data_s;
  logic [DATA_WIDTH-1:0]   tx_data_r, tx_data_s;
  logic                    rf_wr_en_r, rf_wr_en_s;
  logic                    rf_rd_en_r, rf_rd_en_s;
  logic                    tx_valid_r, tx_valid_s;
  logic                    cmd_error_r, cmd_error_s;
  logic                    addr_ok_s;

  // An address byte is legal only when every bit above the address field is zero.
  assign addr_ok_s = ((rx_data >> ADDR_WIDTH) == {DATA_WIDTH{1'b0}});

  // Next-state and next-output decode; strobes and the error pulse default low.
  always_comb begin
    state_s      = state_r;
    rf_addr_s    = rf_addr_r;
    rf_wr_data_s = rf_wr_data_r;
    tx_data_s    = tx_data_r;
    tx_valid_s   = tx_valid_r;
    rf_wr_en_s   = 1'b0;
    rf_rd_en_s   = 1'b0;
    cmd_error_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (rx_valid) begin
          if (rx_data == OP_WRITE) begin
            state_s = WR_ADDR;
          end else if (rx_data == OP_READ) begin
            state_s = RD_ADDR;
          end else begin
            cmd_error_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WR_ADDR, RD_ADDR: begin
        if (rx_valid) begin
          if (!addr_ok_s) begin
            state_s     = IDLE;
            cmd_error_s = 1'b1;
          end else if (state_r == WR_ADDR) begin
            rf_addr_s = rx_data[ADDR_WIDTH-1:0];
            state_s   = WR_DATA;
          end else begin
            rf_addr_s  = rx_data[ADDR_WIDTH-1:0];
            rf_rd_en_s = 1'b1;
            state_s    = RD_WAIT;
          end
        end else begin
          state_s = state_r;
        end
      end
      WR_DATA: begin
        if (rx_valid) begin
          rf_wr_data_s = rx_data;
          rf_wr_en_s   = 1'b1;
          state_s      = IDLE;
        end else begin
          state_s = WR_DATA;
        end
      end
      RD_WAIT: begin
        // A stray byte here is dropped but still flagged; the read carries on.
        cmd_error_s = rx_valid;
        if (rf_rd_valid) begin
          tx_data_s  = rf_rd_data;
          tx_valid_s = 1'b1;
          state_s    = TX_PUSH;
        end else begin
          state_s = RD_WAIT;
        end
      end
      TX_PUSH: begin
        cmd_error_s = rx_valid;
        if (tx_ready) begin
          tx_valid_s = 1'b0;
          state_s    = IDLE;
        end else begin
          tx_valid_s = 1'b1;
        end
      end
      default: begin
        state_s    = IDLE;
        tx_valid_s = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      rf_addr_r    <= {ADDR_WIDTH{1'b0}};
      rf_wr_data_r <= {DATA_WIDTH{1'b0}};
      tx_data_r    <= {DATA_WIDTH{1'b0}};
      rf_wr_en_r   <= 1'b0;
      rf_rd_en_r   <= 1'b0;
      tx_valid_r   <= 1'b0;
      cmd_error_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      rf_addr_r    <= rf_addr_s;
      rf_wr_data_r <= rf_wr_data_s;
      tx_data_r    <= tx_data_s;
      rf_wr_en_r   <= rf_wr_en_s;
      rf_rd_en_r   <= rf_rd_en_s;
      tx_valid_r   <= tx_valid_s;
      cmd_error_r  <= cmd_error_s;
    end
  end

  assign rf_addr    = rf_addr_r;
  assign rf_wr_data = rf_wr_data_r;
  assign rf_wr_en   = rf_wr_en_r;
  assign rf_rd_en   = rf_rd_en_r;
  assign tx_data    = tx_data_r;
  assign tx_valid   = tx_valid_r;
  assign cmd_error  = cmd_error_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_uart_cmd_controller.sv
// Self-checking bench for uart_cmd_controller: directed command scenarios followed by
// randomized command streams checked against a register-file model kept in the bench.
module tb_uart_cmd_controller;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wr_data;
  logic          rf_wr_en;
  logic          rf_rd_en;
  logic [DW-1:0] rf_rd_data;
  logic          rf_rd_valid;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          busy;
  logic          cmd_error;

  uart_cmd_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rf_addr(rf_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, err_cnt = 0, xfer_cnt = 0, tv_cnt = 0;
  int exp_wr = 0, exp_rd = 0, exp_err = 0;
  logic [DW-1:0] ref_mem   [0:15];
  logic [DW-1:0] bench_mem [0:15];

  // Cycle monitor, sampled just before each rising edge; also acts as the register file.
  always @(negedge clk) begin
    #4;
    if (rf_wr_en) begin
      wr_cnt++;
      bench_mem[rf_addr] = rf_wr_data;
    end
    if (rf_rd_en) rd_cnt++;
    if (rf_wr_en && rf_rd_en) both_cnt++;
    if (cmd_error) err_cnt++;
    if (tx_valid) tv_cnt++;
    if (tx_valid && tx_ready) xfer_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Called at a falling edge; presents one byte for one cycle, returns at the next falling edge.
  task automatic send_byte(input logic [DW-1:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = DW'($urandom_range(0, 255));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    send_byte(8'hAA);
    chk("wr_op_busy", {31'd0, busy}, 32'd1);
    send_byte({4'h0, a});
    chk("wr_addr_busy", {31'd0, busy}, 32'd1);
    chk("wr_addr_noerr", {31'd0, cmd_error}, 32'd0);
    send_byte(d);
    chk("wr_en", {31'd0, rf_wr_en}, 32'd1);
    chk("wr_addr", {28'd0, rf_addr}, {28'd0, a});
    chk("wr_data", {24'd0, rf_wr_data}, {24'd0, d});
    chk("wr_idle", {31'd0, busy}, 32'd0);
    ref_mem[a] = d;
    exp_wr++;
  endtask

  // Read with rd_valid delay dly, k not-ready cycles, optional stray bytes during the wait/push.
  task automatic do_read(input logic [AW-1:0] a, input int dly, input int k,
                         input bit inj_wait, input bit inj_push);
    int tv0, xf0;
    send_byte(8'hBB);
    chk("rd_op_busy", {31'd0, busy}, 32'd1);
    send_byte({4'h0, a});
    chk("rd_en", {31'd0, rf_rd_en}, 32'd1);
    chk("rd_addr", {28'd0, rf_addr}, {28'd0, a});
    for (int i = 0; i < dly; i++) begin
      if (inj_wait && i == 0) begin
        send_byte(DW'($urandom_range(0, 255)));
        chk("rd_wait_err", {31'd0, cmd_error}, 32'd1);
        exp_err++;
      end else begin
        @(negedge clk);
      end
      chk("rd_en_once", {31'd0, rf_rd_en}, 32'd0);
      chk("rd_wait_busy", {31'd0, busy}, 32'd1);
    end
    tv0 = tv_cnt;
    xf0 = xfer_cnt;
    rf_rd_valid = 1'b1;
    rf_rd_data  = bench_mem[a];
    @(negedge clk);
    rf_rd_valid = 1'b0;
    rf_rd_data  = DW'($urandom_range(0, 255));
    for (int j = 0; j < k; j++) begin
      chk("tx_valid_held", {31'd0, tx_valid}, 32'd1);
      chk("tx_data_held", {24'd0, tx_data}, {24'd0, ref_mem[a]});
      if (inj_push && j == 0) begin
        send_byte(DW'($urandom_range(0, 255)));
        chk("tx_push_err", {31'd0, cmd_error}, 32'd1);
        exp_err++;
      end else begin
        @(negedge clk);
      end
    end
    chk("tx_valid", {31'd0, tx_valid}, 32'd1);
    chk("tx_data", {24'd0, tx_data}, {24'd0, ref_mem[a]});
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("tx_done_valid", {31'd0, tx_valid}, 32'd0);
    chk("tx_done_idle", {31'd0, busy}, 32'd0);
    chk("tx_valid_cycles", 32'(tv_cnt - tv0), 32'(k + 1));
    chk("tx_one_xfer", 32'(xfer_cnt - xf0), 32'd1);
    exp_rd++;
  endtask

  task automatic bad_op(input logic [DW-1:0] b);
    send_byte(b);
    chk("badop_err", {31'd0, cmd_error}, 32'd1);
    chk("badop_idle", {31'd0, busy}, 32'd0);
    exp_err++;
  endtask

  task automatic bad_addr(input logic [DW-1:0] op, input logic [DW-1:0] ab);
    send_byte(op);
    send_byte(ab);
    chk("badaddr_err", {31'd0, cmd_error}, 32'd1);
    chk("badaddr_idle", {31'd0, busy}, 32'd0);
    chk("badaddr_nowr", {31'd0, rf_wr_en}, 32'd0);
    chk("badaddr_nord", {31'd0, rf_rd_en}, 32'd0);
    exp_err++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {rf_addr, rf_wr_data, tx_data, rf_wr_en, rf_rd_en, tx_valid, cmd_error, busy}, 32'd0);
  endtask

  initial begin
    logic [DW-1:0] b;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i]   = 8'h00;
      bench_mem[i] = 8'h00;
    end
    reset_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
    rf_rd_data = 8'h00; rf_rd_valid = 1'b0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset_state");
    reset_n = 1'b1;
    @(negedge clk);

    do_write(4'd3, 8'h5C);
    do_write(4'd7, 8'hE1);
    do_read(4'd7, 2, 5, 1'b0, 1'b0);
    bad_op(8'h12);
    @(negedge clk);
    chk("err_one_cycle", {31'd0, cmd_error}, 32'd0);
    do_write(4'd1, 8'hFF);
    bad_addr(8'hAA, 8'h10);
    do_write(4'd2, 8'h9D);
    do_read(4'd2, 2, 1, 1'b1, 1'b0);
    do_read(4'd3, 0, 0, 1'b0, 1'b0);

    send_byte(8'hAA);
    send_byte(8'h04);
    #1 reset_n = 1'b0;
    #1 chk_all_zero("reset_mid_cmd");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_write(4'd4, 8'h33);
    do_read(4'd4, 1, 2, 1'b0, 1'b1);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_write(AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)));
        4, 5, 6, 7: do_read(AW'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        8: begin
          b = DW'($urandom_range(0, 255));
          while (b == 8'hAA || b == 8'hBB) b = DW'($urandom_range(0, 255));
          bad_op(b);
        end
        default: bad_addr($urandom_range(0, 1) ? 8'hAA : 8'hBB, DW'($urandom_range(16, 255)));
      endcase
      if ($urandom_range(0, 3) == 0) begin
        rf_rd_valid = 1'b1;
        rf_rd_data  = DW'($urandom_range(0, 255));
        @(negedge clk);
        rf_rd_valid = 1'b0;
        chk("stray_rdvalid", {30'd0, tx_valid, busy}, 32'd0);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("total_wr", 32'(wr_cnt), 32'(exp_wr));
    chk("total_rd", 32'(rd_cnt), 32'(exp_rd));
    chk("total_xfer", 32'(xfer_cnt), 32'(exp_rd));
    chk("total_err", 32'(err_cnt), 32'(exp_err));
    chk("never_both", 32'(both_cnt), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_controller.md
UART_CMD_CONTROLLER -- requirements
Module: uart_cmd_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, UART byte width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register-file address width (ADDR_WIDTH <= DATA_WIDTH).
REQ-003 SHALL have port clk  in  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rx_data  in  DATA_WIDTH  received byte from UART receiver.
REQ-006 SHALL have port rx_valid  in  1  one-cycle pulse per received byte.
REQ-007 SHALL have port rf_addr  out  ADDR_WIDTH  register-file address.
REQ-008 SHALL have port rf_wr_data  out  DATA_WIDTH  register-file write data.
REQ-009 SHALL have port rf_wr_en  out  1  one-cycle write strobe.
REQ-010 SHALL have port rf_rd_en  out  1  one-cycle read strobe.
REQ-011 SHALL have port rf_rd_data  in  DATA_WIDTH  register-file read data.
REQ-012 SHALL have port rf_rd_valid  in  1  read data valid, any cycle at or after rf_rd_en.
REQ-013 SHALL have port tx_data  out  DATA_WIDTH  response byte toward TX FIFO.
REQ-014 SHALL have port tx_valid  out  1  response byte valid.
REQ-015 SHALL have port tx_ready  in  1  TX FIFO can accept (not full).
REQ-016 SHALL have port busy  out  1  high whenever state != IDLE.
REQ-017 SHALL have port cmd_error  out  1  one-cycle error pulse.

Function
REQ-018 SHALL implement states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_PUSH; all outputs except busy registered.
REQ-019 IDLE + rx_valid: rx_data=0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other value -> stay IDLE, cmd_error pulse next cycle.
REQ-020 WR_ADDR/RD_ADDR + rx_valid: if rx_data[DATA_WIDTH-1:ADDR_WIDTH] != 0 -> IDLE, cmd_error pulse; else latch rf_addr = rx_data[ADDR_WIDTH-1:0].
REQ-021 WR_ADDR with valid address -> WR_DATA.
REQ-022 RD_ADDR with valid address -> RD_WAIT; rf_rd_en high exactly the cycle after the address byte's rx_valid.
REQ-023 WR_DATA + rx_valid -> rf_wr_data = rx_data, rf_wr_en high exactly the following cycle, state -> IDLE.
REQ-024 RD_WAIT: on rf_rd_valid, latch tx_data = rf_rd_data, assert tx_valid next cycle, state -> TX_PUSH.
REQ-025 TX_PUSH: tx_valid and tx_data held stable until a cycle with tx_ready=1; that cycle is the transfer; tx_valid low next cycle, state -> IDLE.
REQ-026 rx_valid in RD_WAIT or TX_PUSH: byte dropped, cmd_error pulse, state and tx_data unchanged.
REQ-027 rf_rd_valid outside RD_WAIT: ignored.
REQ-028 rf_wr_en and rf_rd_en SHALL never be high in the same cycle; each strobe exactly one cycle per command.
REQ-029 Minimum latency: write strobe 1 cycle after data byte; tx_valid 1 cycle after rf_rd_valid.
REQ-030 Back-to-back: command byte on the cycle after return to IDLE SHALL be accepted.
REQ-031 cmd_error SHALL be a registered one-cycle pulse per error event; no other state affected.

Reset
REQ-032 reset_n low SHALL immediately force state IDLE, rf_addr=0, rf_wr_data=0, tx_data=0, rf_wr_en=0, rf_rd_en=0, tx_valid=0, cmd_error=0, busy=0.
REQ-033 Reset mid-command (any state) SHALL discard partial command; first byte after release is decoded as opcode.

Verification
REQ-034 Bytes AA,03,5C -> rf_wr_en one cycle, rf_addr=3, rf_wr_data=0x5C, busy low after.
REQ-035 Bytes BB,07, rf_rd_valid with rf_rd_data=0xE1 two cycles after rf_rd_en, tx_ready=0 for 5 cycles then 1 -> tx_valid held 6 cycles with tx_data=0xE1, one transfer.
REQ-036 Byte 0x12 in IDLE -> single cmd_error pulse, no strobes; then AA,01,FF completes normally.
REQ-037 Bytes AA,10 (ADDR_WIDTH=4) -> cmd_error pulse, return to IDLE, no rf_wr_en.
REQ-038 BB,02 then extra byte 0x55 during RD_WAIT -> cmd_error pulse, read response still delivered.
REQ-039 reset_n low after AA,04 -> all outputs 0; after release AA,04,33 writes 0x33 to address 4.
